// File: rtl/hello_scroller_pkg.sv
// hello_scroller shared types: character codes, frame geometry, FSM states.
// Optional bounce mode is selected with SCROLL_BOUNCE_EN in hello_scroller.sv.
package hello_pkg;

  localparam int CODE_W     = 3;
  localparam int NUM_DIGITS = 8;
  localparam int MSG_CHARS  = 5;
  localparam int MSG_W      = CODE_W * MSG_CHARS;
  localparam int FRAME_W    = CODE_W * NUM_DIGITS;
  localparam int POS_W      = $clog2(NUM_DIGITS);

  localparam logic [CODE_W-1:0] CHAR_H     = 3'b000;
  localparam logic [CODE_W-1:0] CHAR_E     = 3'b001;
  localparam logic [CODE_W-1:0] CHAR_L     = 3'b010;
  localparam logic [CODE_W-1:0] CHAR_O     = 3'b011;
  localparam logic [CODE_W-1:0] CHAR_BLANK = 3'b111;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  // digit 7 moves to digit 0
  function automatic logic [FRAME_W-1:0] rot_left(
    input logic [FRAME_W-1:0] f
  );
    return {f[FRAME_W-CODE_W-1:0],
            f[FRAME_W-1 -: CODE_W]};
  endfunction

  function automatic logic [FRAME_W-1:0] rot_right(
    input logic [FRAME_W-1:0] f
  );
    return {f[CODE_W-1:0],
            f[FRAME_W-1:CODE_W]};
  endfunction

endpackage

// File: rtl/hello_scroller_if.sv
// Control and display bundle between a scroller master and hello_scroller.
// Inputs carry _i, outputs _o, as seen from the scroller.
interface hello_scroller_if;
  import hello_pkg::*;

  logic               load_i;
  logic [MSG_W-1:0]   msg_in_i;
  logic               run_i;
  logic               dir_i;
  logic               step_i;
  logic [FRAME_W-1:0] codes_o;
  logic [POS_W-1:0]   pos_o;
  logic               wrap_o;

  modport master (
    output load_i,
    output msg_in_i,
    output run_i,
    output dir_i,
    output step_i,
    input  codes_o,
    input  pos_o,
    input  wrap_o
  );

  modport slave (
    input  load_i,
    input  msg_in_i,
    input  run_i,
    input  dir_i,
    input  step_i,
    output codes_o,
    output pos_o,
    output wrap_o
  );

endinterface

// File: rtl/hello_scroller_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles.
// Counter is cleared whenever en_i is low.
module tick_divider #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hello_scroller.sv
// 8-digit H/E/L/O scroller: timed or stepped rotation of a loaded frame.
// Define SCROLL_BOUNCE_EN for ping-pong scrolling while running.
module hello_scroller
  import hello_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input logic              clk_i,
  input logic              rst_i,
  hello_scroller_if.slave  bus
);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] codes_q, codes_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               wrap_q, wrap_d;
  logic               step_q;
  logic               running;
  logic               tick;
  logic               step_rise;
  logic               left;
  logic               rot_l, rot_r;

  assign running   = (state_q == RUNNING);
  assign step_rise = !running && bus.step_i && !step_q;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (running && !bus.load_i),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOPPED: if (bus.run_i)  state_d = RUNNING;
      RUNNING: if (!bus.run_i) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

`ifdef SCROLL_BOUNCE_EN
  logic dir_q, dir_d;

  // Timed steps reverse at the edges instead of wrapping
  always_comb begin
    dir_d = dir_q;
    left  = !bus.dir_i;
    if (tick) begin
      if (!dir_q && pos_q == POS_W'(3))
        dir_d = 1'b1;
      else if (dir_q && pos_q == '0)
        dir_d = 1'b0;
      left = !dir_d;
    end
    if (bus.load_i) dir_d = bus.dir_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dir_q <= bus.dir_i;
    else       dir_q <= dir_d;
  end
`else
  assign left = !bus.dir_i;
`endif

  assign rot_l = (tick || step_rise) &&
                 !bus.load_i && left;
  assign rot_r = (tick || step_rise) &&
                 !bus.load_i && !left;

  always_comb begin
    codes_d = codes_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    unique case (1'b1)
      bus.load_i: begin
        codes_d = {{(NUM_DIGITS-MSG_CHARS){CHAR_BLANK}},
                   bus.msg_in_i};
        pos_d   = '0;
      end
      rot_l: begin
        codes_d = rot_left(codes_q);
        pos_d   = pos_q + 1'b1;
        wrap_d  = (pos_q == '1);
      end
      rot_r: begin
        codes_d = rot_right(codes_q);
        pos_d   = pos_q - 1'b1;
        wrap_d  = (pos_q == '0);
      end
      default: ;
    endcase
`ifdef SCROLL_BOUNCE_EN
    if (tick) wrap_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STOPPED;
      codes_q <= '1;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      codes_q <= codes_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      step_q  <= bus.step_i;
    end
  end

  assign bus.codes_o = codes_q;
  assign bus.pos_o   = pos_q;
  assign bus.wrap_o  = wrap_q;

endmodule

// File: tb/tb_hello_scroller.sv
// Randomized check of hello_scroller against a frame/position model.
// Model follows SCROLL_BOUNCE_EN when the macro is defined.
module tb_hello_scroller;
  import hello_pkg::*;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hello_scroller_if bus();

  hello_scroller #(
    .TICK_DIV (TD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: frame characters, position, divider phase
  int m_frame[8];
  int m_pos;
  int m_cnt;
  bit m_run;
  bit m_prev;
  bit m_wrap;
  bit m_dir;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_codes();
    logic [23:0] r;
    for (int k = 0; k < 8; k++)
      r[3*k +: 3] = 3'(m_frame[(k - m_pos + 8) % 8]);
    return r;
  endfunction

  function automatic logic [14:0] rnd_msg();
    logic [14:0] m;
    int c;
    for (int i = 0; i < 5; i++) begin
      c = $urandom_range(0, 4);
      m[3*i +: 3] = (c == 4) ? 3'b111 : 3'(c);
    end
    return m;
  endfunction

  task automatic model(input bit r, input bit ld,
                       input logic [14:0] msg,
                       input bit run, input bit dir,
                       input bit st);
    bit tk;
    bit rot;
    bit left;
    if (r) begin
      for (int i = 0; i < 8; i++) m_frame[i] = 7;
      m_pos = 0; m_cnt = 0; m_run = 0;
      m_prev = 0; m_wrap = 0; m_dir = dir;
      return;
    end
    tk = 0;
    if (m_run) begin
      if (m_cnt == TD - 1) begin
        tk = 1; m_cnt = 0;
      end else m_cnt++;
    end else m_cnt = 0;
    rot = tk || (!m_run && st && !m_prev);
    left = !dir;
    m_wrap = 0;
    if (ld) begin
      for (int i = 0; i < 5; i++)
        m_frame[i] = int'(msg[3*i +: 3]);
      for (int i = 5; i < 8; i++) m_frame[i] = 7;
      m_pos = 0; m_cnt = 0; m_dir = dir;
    end else if (rot) begin
`ifdef SCROLL_BOUNCE_EN
      if (tk) begin
        if (!m_dir && m_pos == 3) m_dir = 1;
        else if (m_dir && m_pos == 0) m_dir = 0;
        left = !m_dir;
      end
`endif
      m_wrap = left ? (m_pos == 7) : (m_pos == 0);
`ifdef SCROLL_BOUNCE_EN
      if (tk) m_wrap = 0;
`endif
      m_pos = left ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
    end
    m_run = run;
    m_prev = st;
  endtask

  task automatic cyc(input bit r, input bit ld,
                     input logic [14:0] msg,
                     input bit run, input bit dir,
                     input bit st);
    rst          = r;
    bus.load_i   = ld;
    bus.msg_in_i = msg;
    bus.run_i    = run;
    bus.dir_i    = dir;
    bus.step_i   = st;
    model(r, ld, msg, run, dir, st);
    @(negedge clk);
    chk("codes", 32'(bus.codes_o), 32'(exp_codes()));
    chk("pos", 32'(bus.pos_o), 32'(m_pos));
    chk("wrap", 32'(bus.wrap_o), 32'(m_wrap));
  endtask

  logic [14:0] hello;
  logic [14:0] msg_r;
  bit run_r, dir_r;
  int guard;

  initial begin
    hello = {CHAR_H, CHAR_E, CHAR_L, CHAR_L, CHAR_O};
    cyc(1, 0, '0, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    chk("rst_codes", 32'(bus.codes_o), 32'h00FF_FFFF);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, 0);

    cyc(0, 1, hello, 0, 0, 0);
    chk("load_frame", 32'(bus.codes_o),
        32'({9'h1FF, hello}));

    // timed left scroll through a full revolution
    for (int i = 0; i < 8 * TD + 3; i++)
      cyc(0, 0, '0, 1, 0, 0);

    // held step in STOPPED gives a single right rotation
    cyc(0, 1, hello, 0, 1, 0);
    cyc(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0, 1, 1);
    cyc(0, 0, '0, 0, 1, 0);

    // load landing on a tick edge
    cyc(0, 0, '0, 1, 0, 0);
    for (int j = 0; j < 2; j++) begin
      guard = 0;
      while (!(m_run && m_cnt == TD - 1) && guard < 20) begin
        cyc(0, 0, '0, 1, 0, 0);
        guard++;
      end
      chk("tick_wait", 32'(guard < 20), 32'd1);
      cyc(0, 1, rnd_msg(), 1, 0, 0);
      for (int i = 0; i < TD + 2; i++) cyc(0, 0, '0, 1, 0, 0);
    end

    run_r = 0; dir_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) run_r = !run_r;
      if ($urandom_range(0, 19) == 0) dir_r = !dir_r;
      msg_r = rnd_msg();
      cyc($urandom_range(0, 699) == 0,
          $urandom_range(0, 49) == 0, msg_r,
          run_r, dir_r, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
